// File: rtl/cpu_run_controller.sv
// Run/debug sequencer for the microprogrammed CU.
// Turns single-cycle host commands into CU run-control levels and pulses. It also
// counts fetched instructions, stops on a PC breakpoint and faults on a hung
// microprogram.
module cpu_run_controller #(
   parameter int unsigned PC_W        = 8,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned WDOG_CYCLES = 1024
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cmd_run,
   input  logic             i_cmd_step,
   input  logic             i_cmd_stop,
   input  logic             i_cmd_clear,
   input  logic             i_if_stage,
   input  logic             i_halt,
   input  logic [PC_W-1:0]  i_pc,
   input  logic             i_bp_en,
   input  logic [PC_W-1:0]  i_bp_addr,
   output logic             o_cpu_start,
   output logic             o_step_exec,
   output logic             o_next_instr,
   output logic [2:0]       o_state,
   output logic [CNT_W-1:0] o_instr_count,
   output logic             o_bp_hit,
   output logic             o_timeout
);

   localparam int unsigned WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
   // Expiry fires on the cycle the count would reach WDOG_CYCLES-1.
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 2);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_STEP   = 3'd2,
      S_BREAK  = 3'd3,
      S_HALTED = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   state_t            state;
   state_t            state_n;
   logic              if_q;
   logic              if_rise;
   logic              active;
   logic              bp_match;
   logic              bp_skip;
   logic              bp_skip_n;
   logic              wdog_expire;
   logic [WDOG_W-1:0] wdog;
   logic [WDOG_W-1:0] wdog_n;
   logic [CNT_W-1:0]  count_n;
   logic              pulse_n;
   logic              start_n;
   logic              step_exec_n;
   logic              bp_hit_n;
   logic              timeout_n;

   // Event decode shared by the FSM and the datapath.
   always_comb begin
      if_rise     = i_if_stage & ~if_q;
      active      = (state == S_RUN) || (state == S_STEP) || (state == S_BREAK);
      bp_match    = i_bp_en & (i_pc == i_bp_addr) & ~bp_skip;
      wdog_expire = (state == S_RUN) & ~if_rise & (wdog == WDOG_LAST);
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and step-pulse logic.
   // Priority: clear > halt > watchdog > breakpoint > stop > step > run.
   always_comb begin
      state_n = state;
      pulse_n = 1'b0;
      if (i_cmd_clear) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_cmd_step) begin
                  state_n = S_STEP;
               end else if (i_cmd_run) begin
                  state_n = S_RUN;
               end
            end
            S_RUN: begin
               if (i_halt) begin
                  state_n = S_HALTED;
               end else if (wdog_expire) begin
                  state_n = S_FAULT;
               end else if (if_rise && bp_match) begin
                  state_n = S_BREAK;
               end else if (i_cmd_stop) begin
                  state_n = S_STEP;
               end
            end
            S_STEP: begin
               if (i_halt) begin
                  state_n = S_HALTED;
               end else if (i_cmd_step) begin
                  pulse_n = ~o_next_instr;
               end else if (i_cmd_run) begin
                  state_n = S_RUN;
               end
            end
            S_BREAK: begin
               if (i_halt) begin
                  state_n = S_HALTED;
               end else if (i_cmd_step) begin
                  state_n = S_STEP;
                  pulse_n = ~o_next_instr;
               end else if (i_cmd_run) begin
                  state_n = S_RUN;
               end
            end
            S_HALTED, S_FAULT: begin
               state_n = state;
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

   // Watchdog, instruction counter, breakpoint-resume mask and output decode.
   always_comb begin
      wdog_n      = '0;
      count_n     = o_instr_count;
      bp_skip_n   = bp_skip;
      start_n     = 1'b0;
      step_exec_n = 1'b0;
      bp_hit_n    = 1'b0;
      timeout_n   = 1'b0;

      if (!i_cmd_clear && (state == S_RUN) && (state_n == S_RUN) && !if_rise) begin
         wdog_n = wdog + WDOG_W'(1);
      end

      if (i_cmd_clear) begin
         count_n = '0;
      end else if (active && if_rise && (o_instr_count != CNT_MAX)) begin
         count_n = o_instr_count + CNT_W'(1);
      end

      // The first fetch after leaving BREAK must not re-trigger the same breakpoint.
      if (i_cmd_clear) begin
         bp_skip_n = 1'b0;
      end else if ((state == S_BREAK) && (state_n != S_BREAK)) begin
         bp_skip_n = 1'b1;
      end else if (if_rise && ((state == S_RUN) || (state == S_STEP))) begin
         bp_skip_n = 1'b0;
      end

      case (state_n)
         S_RUN: begin
            start_n = 1'b1;
         end
         S_STEP: begin
            start_n     = 1'b1;
            step_exec_n = 1'b1;
         end
         S_BREAK: begin
            start_n     = 1'b1;
            step_exec_n = 1'b1;
            bp_hit_n    = 1'b1;
         end
         S_FAULT: begin
            timeout_n = 1'b1;
         end
         default: begin
            start_n = 1'b0;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         if_q          <= 1'b0;
         wdog          <= '0;
         bp_skip       <= 1'b0;
         o_instr_count <= '0;
         o_next_instr  <= 1'b0;
         o_cpu_start   <= 1'b0;
         o_step_exec   <= 1'b0;
         o_bp_hit      <= 1'b0;
         o_timeout     <= 1'b0;
      end else begin
         if_q          <= i_if_stage;
         wdog          <= wdog_n;
         bp_skip       <= bp_skip_n;
         o_instr_count <= count_n;
         o_next_instr  <= pulse_n;
         o_cpu_start   <= start_n;
         o_step_exec   <= step_exec_n;
         o_bp_hit      <= bp_hit_n;
         o_timeout     <= timeout_n;
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: per-cycle vector table plus hand-written
// sequences for reset, watchdog and counter saturation.
module tb_cpu_run_controller;

   localparam int unsigned PC_W  = 8;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned WDOG  = 16;

   logic             i_clk = 1'b0;
   logic             i_rst_n;
   logic             i_cmd_run, i_cmd_step, i_cmd_stop, i_cmd_clear;
   logic             i_if_stage, i_halt, i_bp_en;
   logic [PC_W-1:0]  i_pc, i_bp_addr;
   logic             o_cpu_start, o_step_exec, o_next_instr, o_bp_hit, o_timeout;
   logic [2:0]       o_state;
   logic [CNT_W-1:0] o_instr_count;

   int n_cmp = 0;
   int n_err = 0;

   cpu_run_controller #(.PC_W(PC_W), .CNT_W(CNT_W), .WDOG_CYCLES(WDOG)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_cmd_run(i_cmd_run), .i_cmd_step(i_cmd_step), .i_cmd_stop(i_cmd_stop),
      .i_cmd_clear(i_cmd_clear), .i_if_stage(i_if_stage), .i_halt(i_halt),
      .i_pc(i_pc), .i_bp_en(i_bp_en), .i_bp_addr(i_bp_addr),
      .o_cpu_start(o_cpu_start), .o_step_exec(o_step_exec), .o_next_instr(o_next_instr),
      .o_state(o_state), .o_instr_count(o_instr_count), .o_bp_hit(o_bp_hit),
      .o_timeout(o_timeout)
   );

   always #5 i_clk = ~i_clk;

   // One row = inputs held for one cycle, outputs expected after that edge.
   typedef struct {
      logic [5:0] cmds;    // {run, step, stop, clear, if_stage, halt}
      logic [7:0] pc;
      logic       bp_en;
      logic [2:0] st;
      logic [4:0] flags;   // {start, step_exec, next_instr, bp_hit, timeout}
      logic [3:0] cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [5:0] cmds, input logic [7:0] pc, input logic bp_en,
                      input logic [2:0] st, input logic [4:0] flags, input logic [3:0] cnt);
      vec_t v;
      v.cmds = cmds; v.pc = pc; v.bp_en = bp_en; v.st = st; v.flags = flags; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   function automatic logic [11:0] obs();
      return {o_state, o_cpu_start, o_step_exec, o_next_instr, o_bp_hit, o_timeout, o_instr_count};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      {i_cmd_run, i_cmd_step, i_cmd_stop, i_cmd_clear, i_if_stage, i_halt} = 6'b0;
      i_pc = 8'h00;
      i_bp_en = 1'b0;
   endtask

   task automatic pulse_clear();
      i_cmd_clear = 1'b1;
      tick();
      i_cmd_clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int n;
      i_rst_n = 1'b0;
      i_bp_addr = 8'h10;
      idle_inputs();
      repeat (2) @(posedge i_clk);
      #1;
      check("reset_outputs", 32'(obs()), 32'h0);
      i_rst_n = 1'b1;
      tick();
      check("reset_release_state", 32'(o_state), 32'd0);

      // Free run, 5 fetches, halt.
      add(6'b100000, 8'h00, 0, 3'd1, 5'b10000, 4'd0);
      add(6'b000010, 8'h00, 0, 3'd1, 5'b10000, 4'd1);
      add(6'b000000, 8'h00, 0, 3'd1, 5'b10000, 4'd1);
      add(6'b000010, 8'h00, 0, 3'd1, 5'b10000, 4'd2);
      add(6'b000000, 8'h00, 0, 3'd1, 5'b10000, 4'd2);
      add(6'b000010, 8'h00, 0, 3'd1, 5'b10000, 4'd3);
      add(6'b000000, 8'h00, 0, 3'd1, 5'b10000, 4'd3);
      add(6'b000010, 8'h00, 0, 3'd1, 5'b10000, 4'd4);
      add(6'b000000, 8'h00, 0, 3'd1, 5'b10000, 4'd4);
      add(6'b000010, 8'h00, 0, 3'd1, 5'b10000, 4'd5);
      add(6'b000001, 8'h00, 0, 3'd4, 5'b00000, 4'd5);
      add(6'b100000, 8'h00, 0, 3'd4, 5'b00000, 4'd5);
      add(6'b000100, 8'h00, 0, 3'd0, 5'b00000, 4'd0);
      // Breakpoint at 0x10, step out, resume without re-break, then break again.
      add(6'b100000, 8'h00, 1, 3'd1, 5'b10000, 4'd0);
      add(6'b000010, 8'h05, 1, 3'd1, 5'b10000, 4'd1);
      add(6'b000000, 8'h05, 1, 3'd1, 5'b10000, 4'd1);
      add(6'b000010, 8'h10, 1, 3'd3, 5'b11010, 4'd2);
      add(6'b000010, 8'h10, 1, 3'd3, 5'b11010, 4'd2);
      add(6'b010000, 8'h10, 1, 3'd2, 5'b11100, 4'd2);
      add(6'b000000, 8'h10, 1, 3'd2, 5'b11000, 4'd2);
      add(6'b100000, 8'h10, 1, 3'd1, 5'b10000, 4'd2);
      add(6'b000010, 8'h10, 1, 3'd1, 5'b10000, 4'd3);
      add(6'b000000, 8'h10, 1, 3'd1, 5'b10000, 4'd3);
      add(6'b000010, 8'h10, 1, 3'd3, 5'b11010, 4'd4);
      add(6'b000100, 8'h10, 1, 3'd0, 5'b00000, 4'd0);
      // Single step from IDLE: entry gives no pulse, then three pulses.
      add(6'b010000, 8'h00, 0, 3'd2, 5'b11000, 4'd0);
      add(6'b010000, 8'h00, 0, 3'd2, 5'b11100, 4'd0);
      add(6'b000000, 8'h00, 0, 3'd2, 5'b11000, 4'd0);
      add(6'b010000, 8'h00, 0, 3'd2, 5'b11100, 4'd0);
      add(6'b000000, 8'h00, 0, 3'd2, 5'b11000, 4'd0);
      add(6'b010000, 8'h00, 0, 3'd2, 5'b11100, 4'd0);
      add(6'b000000, 8'h00, 0, 3'd2, 5'b11000, 4'd0);
      add(6'b001000, 8'h00, 0, 3'd2, 5'b11000, 4'd0);
      add(6'b000010, 8'h00, 0, 3'd2, 5'b11000, 4'd1);
      add(6'b000001, 8'h00, 0, 3'd4, 5'b00000, 4'd1);
      add(6'b000100, 8'h00, 0, 3'd0, 5'b00000, 4'd0);
      // Step+run in IDLE picks STEP; back-to-back step commands never give adjacent pulses.
      add(6'b110000, 8'h00, 0, 3'd2, 5'b11000, 4'd0);
      add(6'b010000, 8'h00, 0, 3'd2, 5'b11100, 4'd0);
      add(6'b010000, 8'h00, 0, 3'd2, 5'b11000, 4'd0);
      add(6'b010000, 8'h00, 0, 3'd2, 5'b11100, 4'd0);
      add(6'b000100, 8'h00, 0, 3'd0, 5'b00000, 4'd0);
      // Collisions and ignored commands.
      add(6'b100000, 8'h00, 0, 3'd1, 5'b10000, 4'd0);
      add(6'b001001, 8'h00, 0, 3'd4, 5'b00000, 4'd0);
      add(6'b100100, 8'h00, 0, 3'd0, 5'b00000, 4'd0);
      add(6'b100000, 8'h00, 0, 3'd1, 5'b10000, 4'd0);
      add(6'b001000, 8'h00, 0, 3'd2, 5'b11000, 4'd0);
      add(6'b100000, 8'h00, 0, 3'd1, 5'b10000, 4'd0);
      add(6'b010000, 8'h00, 0, 3'd1, 5'b10000, 4'd0);
      add(6'b001010, 8'h10, 1, 3'd3, 5'b11010, 4'd1);
      add(6'b110000, 8'h10, 1, 3'd2, 5'b11100, 4'd1);
      add(6'b000100, 8'h00, 0, 3'd0, 5'b00000, 4'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         {i_cmd_run, i_cmd_step, i_cmd_stop, i_cmd_clear, i_if_stage, i_halt} = tbl[i].cmds;
         i_pc = tbl[i].pc;
         i_bp_en = tbl[i].bp_en;
         tick();
         check($sformatf("row%0d", i), 32'(obs()),
               32'({tbl[i].st, tbl[i].flags, tbl[i].cnt}));
      end
      idle_inputs();

      // Watchdog: 15 cycles in RUN without a fetch ends in FAULT.
      i_cmd_run = 1'b1;
      tick();
      i_cmd_run = 1'b0;
      check("wdog_run_entry", 32'(o_state), 32'd1);
      n = 0;
      while (o_state != 3'd5 && n < 40) begin
         tick();
         n++;
      end
      check("wdog_cycles_to_fault", 32'(n), 32'd15);
      check("wdog_fault_flags", 32'({o_cpu_start, o_step_exec, o_timeout}), 32'b001);
      i_cmd_run = 1'b1;
      tick();
      i_cmd_run = 1'b0;
      check("fault_ignores_run", 32'(o_state), 32'd5);
      pulse_clear();
      check("wdog_clear", 32'(obs()), 32'h0);

      // A fetch restarts the watchdog window.
      i_cmd_run = 1'b1;
      tick();
      i_cmd_run = 1'b0;
      repeat (10) tick();
      i_if_stage = 1'b1;
      tick();
      i_if_stage = 1'b0;
      n = 0;
      while (o_state != 3'd5 && n < 40) begin
         tick();
         n++;
      end
      check("wdog_rearm_cycles", 32'(n), 32'd15);
      check("wdog_rearm_count", 32'(o_instr_count), 32'd1);
      pulse_clear();

      // Counter saturates at all-ones.
      i_cmd_run = 1'b1;
      tick();
      i_cmd_run = 1'b0;
      for (int k = 0; k < 20; k++) begin
         i_if_stage = 1'b1;
         tick();
         i_if_stage = 1'b0;
         tick();
      end
      check("sat_count", 32'({o_state, o_instr_count}), 32'({3'd1, 4'hF}));
      i_halt = 1'b1;
      tick();
      i_halt = 1'b0;
      check("sat_halted", 32'(obs()), 32'({3'd4, 5'b00000, 4'hF}));
      pulse_clear();

      // Asynchronous reset in the middle of RUN.
      i_cmd_run = 1'b1;
      tick();
      i_cmd_run = 1'b0;
      i_if_stage = 1'b1;
      tick();
      i_if_stage = 1'b0;
      tick();
      check("pre_reset_run", 32'({o_state, o_instr_count}), 32'({3'd1, 4'd1}));
      #2;
      i_rst_n = 1'b0;
      #1;
      check("async_reset_outputs", 32'(obs()), 32'h0);
      #2;
      i_rst_n = 1'b1;
      tick();
      check("post_reset_state", 32'(obs()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
